// File: rtl/command_sequencer.sv
// Trace command sequencer: a command FIFO feeding an FSM that issues cache commands or clear/print requests.
// Optional feature macro CMD_STATS_EN adds saturating read/write/fetch/drop counters.
module command_sequencer #(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 14,
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid_in,
  output logic                cmd_ready_out,
  input  logic [3:0]          cmd_n_in,
  input  logic [ADDR_W-1:0]   cmd_addr_in,
  output logic                issue_valid,
  input  logic                issue_ready,
  output logic [3:0]          issue_n,
  output logic [TAG_W-1:0]    issue_tag,
  output logic [INDEX_W-1:0]  issue_index,
  output logic [OFFSET_W-1:0] issue_offset,
  output logic                clear_req,
  output logic                print_req,
  input  logic                op_done,
`ifdef CMD_STATS_EN
  output logic [31:0]         read_cnt,
  output logic [31:0]         write_cnt,
  output logic [31:0]         fetch_cnt,
  output logic [31:0]         drop_cnt,
`endif
  output logic                busy
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CLEAR = 2'd2,
    S_PRINT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [3:0]        r_mem_n    [DEPTH];
  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic [3:0]          r_issue_n;
  logic [TAG_W-1:0]    r_issue_tag;
  logic [INDEX_W-1:0]  r_issue_index;
  logic [OFFSET_W-1:0] r_issue_offset;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_load_issue;
  logic              w_handshake;
  logic [3:0]        w_head_n;
  logic [ADDR_W-1:0] w_head_addr;

  assign w_full      = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = cmd_valid_in && !w_full;
  assign w_head_n    = r_mem_n[r_rd_ptr];
  assign w_head_addr = r_mem_addr[r_rd_ptr];
  assign w_handshake = (r_state == S_ISSUE) && issue_ready;

  assign cmd_ready_out = !w_full;
  assign issue_valid   = (r_state == S_ISSUE);
  assign clear_req     = (r_state == S_CLEAR);
  assign print_req     = (r_state == S_PRINT);
  assign busy          = !w_empty || (r_state != S_IDLE);
  assign issue_n       = r_issue_n;
  assign issue_tag     = r_issue_tag;
  assign issue_index   = r_issue_index;
  assign issue_offset  = r_issue_offset;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // The head entry stays in the FIFO until its command completes; unknown codes are popped straight from IDLE.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_drop       = 1'b0;
    w_load_issue = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          if (w_head_n <= 4'd4) begin
            w_next_state = S_ISSUE;
            w_load_issue = 1'b1;
          end else if (w_head_n == 4'd8) begin
            w_next_state = S_CLEAR;
          end else if (w_head_n == 4'd9) begin
            w_next_state = S_PRINT;
          end else begin
            w_pop  = 1'b1;
            w_drop = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (issue_ready) begin
          w_pop        = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_CLEAR, S_PRINT: begin
        if (op_done) begin
          w_pop        = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_n[r_wr_ptr]    <= cmd_n_in;
      r_mem_addr[r_wr_ptr] <= cmd_addr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_n      <= '0;
      r_issue_tag    <= '0;
      r_issue_index  <= '0;
      r_issue_offset <= '0;
    end else if (w_load_issue) begin
      r_issue_n      <= w_head_n;
      r_issue_tag    <= w_head_addr[ADDR_W-1 -: TAG_W];
      r_issue_index  <= w_head_addr[OFFSET_W +: INDEX_W];
      r_issue_offset <= w_head_addr[OFFSET_W-1:0];
    end
  end

`ifdef CMD_STATS_EN
  logic [31:0] r_read_cnt;
  logic [31:0] r_write_cnt;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_drop_cnt;

  assign read_cnt  = r_read_cnt;
  assign write_cnt = r_write_cnt;
  assign fetch_cnt = r_fetch_cnt;
  assign drop_cnt  = r_drop_cnt;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_cnt  <= '0;
      r_write_cnt <= '0;
      r_fetch_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_handshake && r_issue_n == 4'd0 && r_read_cnt != '1)  r_read_cnt  <= r_read_cnt + 32'd1;
      if (w_handshake && r_issue_n == 4'd1 && r_write_cnt != '1) r_write_cnt <= r_write_cnt + 32'd1;
      if (w_handshake && r_issue_n == 4'd2 && r_fetch_cnt != '1) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_drop && r_drop_cnt != '1)                            r_drop_cnt  <= r_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/command_sequencer.md
COMMAND_SEQUENCER -- requirements
Module: command_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, command FIFO entries; SHALL be a power of 2, at least 2.
REQ-002 Parameter ADDR_W, default 32, trace address width.
REQ-003 Parameter OFFSET_W, default 6, byte-offset bits; parameter INDEX_W, default 14, set-index bits; TAG_W SHALL be derived as ADDR_W-INDEX_W-OFFSET_W (12).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cmd_valid_in  input  1  trace command offered.
REQ-007 cmd_ready_out  output  1  FIFO can accept a command; SHALL equal !full.
REQ-008 cmd_n_in  input  4  trace command code.
REQ-009 cmd_addr_in  input  ADDR_W  trace address.
REQ-010 issue_valid  output  1  decoded cache command presented to the cache stage.
REQ-011 issue_ready  input  1  cache stage accepts the issued command.
REQ-012 issue_n  output  4  issued command code (0,1,2,3,4 only).
REQ-013 issue_tag / issue_index / issue_offset  output  TAG_W / INDEX_W / OFFSET_W  address fields, tag in MSBs, offset in LSBs.
REQ-014 clear_req  output  1  request to clear all cache state (code 8); print_req  output  1  request to dump cache contents (code 9).
REQ-015 op_done  input  1  cache stage finished the outstanding clear or print.
REQ-016 busy  output  1  high while the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-017 A push SHALL occur when cmd_valid_in && cmd_ready_out at a rising edge; a push while full SHALL NOT be accepted, even if a pop occurs in the same cycle.
REQ-018 FIFO pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH; full is count==DEPTH, empty is count==0.
REQ-019 FSM states SHALL be IDLE, ISSUE, CLEAR and PRINT.
REQ-020 In IDLE with FIFO non-empty, the FSM SHALL decode the head entry: codes 0-4 go to ISSUE; 8 goes to CLEAR; 9 goes to PRINT.
REQ-021 Codes 5, 6, 7 and 10-15 SHALL be popped in IDLE in one cycle, with no output activity, and the FSM SHALL stay in IDLE.
REQ-022 On entry to ISSUE, issue_valid, issue_n and the address fields SHALL be registered from the head entry; they SHALL be held stable until issue_valid && issue_ready.
REQ-023 On the ISSUE handshake, the head SHALL be popped, issue_valid SHALL drop on the next cycle, and the FSM SHALL return to IDLE.
REQ-024 A command pushed into an empty FIFO at edge k SHALL present issue_valid=1 after edge k+1 (2-cycle latency).
REQ-025 Throughput SHALL be one issued command per 2 cycles, with issue_ready held high.
REQ-026 In CLEAR, clear_req SHALL be held high until op_done=1; on op_done the head SHALL be popped, clear_req SHALL drop and the FSM SHALL return to IDLE.
REQ-027 PRINT SHALL behave identically using print_req.
REQ-028 clear_req, print_req and issue_valid SHALL be mutually exclusive.
REQ-029 op_done SHALL be ignored outside CLEAR and PRINT; issue_ready SHALL be ignored outside ISSUE.
REQ-030 Pushes SHALL continue to be accepted in every state while not full.

Reset
REQ-031 When rst=1 at an edge: FIFO emptied, pointers 0, FSM IDLE, and issue_valid, clear_req, print_req, busy and all issue fields driven 0.
REQ-032 cmd_ready_out SHALL be 1 after reset.
REQ-033 rst SHALL take priority over a simultaneous push, pop or handshake.
REQ-034 Reset mid-ISSUE, mid-CLEAR or mid-PRINT SHALL discard the outstanding command, with no pop or acknowledge pending afterwards.

Configuration
REQ-035 Macro CMD_STATS_EN: when defined, the block SHALL add 32-bit outputs read_cnt, write_cnt, fetch_cnt and drop_cnt.
REQ-036 With CMD_STATS_EN defined, read_cnt, write_cnt and fetch_cnt SHALL increment on ISSUE handshakes for codes 0, 1 and 2 respectively.
REQ-037 With CMD_STATS_EN defined, drop_cnt SHALL increment on each code popped per REQ-021.
REQ-038 With CMD_STATS_EN defined, all four counters SHALL saturate at 0xFFFFFFFF and SHALL reset to 0.
REQ-039 Without CMD_STATS_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-040 Push n=0, addr=0x1234_5678 into an empty FIFO, with issue_ready=1 -> two edges later issue_valid=1, issue_n=0, tag=0x123, index=0x1159, offset=0x38; one cycle later issue_valid=0.
REQ-041 Push 8 commands with issue_ready=0 -> cmd_ready_out=0 after the 8th; a 9th push is rejected; raising issue_ready drains all 8 in push order.
REQ-042 Push n=8, then n=2 -> clear_req=1 held for 5 cycles until op_done pulses; the n=2 issue follows only after clear_req drops.
REQ-043 Push n=6, then n=1 -> the n=6 entry is silently dropped (drop_cnt=1 with CMD_STATS_EN) and n=1 issues.
REQ-044 rst=1 while issue_valid=1 and 3 entries are queued -> next cycle issue_valid=0, busy=0, cmd_ready_out=1; no stale entry is issued afterwards.
REQ-045 Push n=9 with op_done already high -> print_req=1 for exactly one cycle, then FSM returns to IDLE with busy=0.
